// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
// Shared CPU definitions for the load/store path. The memory controller
// imports the same package, so both sides agree on these definitions:
//   - bit positions of the ls_op fields {rw, width[1:0], sign}
//   - access width encodings (W/H/B/illegal)
//   - error cause codes
//   - the LSU state type
//   - helper functions for alignment checks, byte enables and lane
//     replication of store data
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

    localparam int OP_RW_BIT    = 3;
    localparam int OP_WIDTH_MSB = 2;
    localparam int OP_WIDTH_LSB = 1;
    localparam int OP_SIGN_BIT  = 0;

    typedef enum logic [1:0] {
        WIDTH_W   = 2'b00,
        WIDTH_H   = 2'b01,
        WIDTH_B   = 2'b10,
        WIDTH_ILL = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_TIMEOUT  = 2'b10,
        CAUSE_ILLEGAL  = 2'b11
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    // Halfwords need an even address and words need a word-aligned address.
    // Bytes can never be misaligned.
    function automatic logic is_misaligned(input width_e width, input logic [1:0] offset);
        logic misaligned;
        case (width)
            WIDTH_W: misaligned = (offset != 2'b00);
            WIDTH_H: misaligned = offset[0];
            default: misaligned = 1'b0;
        endcase
        return misaligned;
    endfunction

    function automatic logic [3:0] byte_enables(input width_e width, input logic [1:0] offset);
        logic [3:0] be;
        case (width)
            WIDTH_B: be = 4'b0001 << offset;
            WIDTH_H: be = 4'b0011 << offset;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Copy the store data onto every lane. The byte enables then select the
    // lane the memory actually writes.
    function automatic logic [31:0] lane_replicate(input width_e width, input logic [31:0] data);
        logic [31:0] rep;
        case (width)
            WIDTH_B: rep = {4{data[7:0]}};
            WIDTH_H: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational read-lane extraction for loads. The addressed byte or
// halfword is shifted down to bit 0, then zero- or sign-extended.
// Ports:
//   i_word   [31:0]  raw word returned by memory
//   i_offset [1:0]   byte offset within the word (address bits [1:0])
//   i_width          access width (W/H/B)
//   i_sign           1 = sign-extend B/H results
//   o_data   [31:0]  aligned, extended load result
// ---------------------------------------------------------------------------
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  width_e      i_width,
    input  logic        i_sign,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_word >> {i_offset, 3'b000};
        case (i_width)
            WIDTH_B: o_data = {{24{i_sign & w_shifted[7]}},  w_shifted[7:0]};
            WIDTH_H: o_data = {{16{i_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Turns single core load/store requests into bus transactions on a
// request/grant + read-valid memory interface.
// Parameter:
//   TIMEOUT_CYCLES  maximum number of WAIT cycles without mem_rvalid before a
//                   load aborts with a timeout error
// Ports:
//   clk_cpu, reset_n          clock; asynchronous active-low reset
//   ls_valid/ls_ready         core request handshake (ready only in IDLE)
//   ls_op[3:0]                {rw, width[1:0], sign}
//   ls_adrs, ls_wdata         byte address and right-justified store data
//   ls_done                   one-cycle completion pulse
//   ls_rdata, ls_err,
//   ls_err_cause              result, valid while ls_done=1
//   mem_req/mem_gnt           bus request held until granted
//   mem_we, mem_adrs, mem_be,
//   mem_wdata                 bus command, driven only while requesting
//   mem_rvalid, mem_rdata     read response
// ---------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_cpu,
    input  logic        reset_n,
    input  logic        ls_valid,
    output logic        ls_ready,
    input  logic [3:0]  ls_op,
    input  logic [31:0] ls_adrs,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [1:0]  ls_err_cause,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [29:0] mem_adrs,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e       r_state;
    lsu_state_e       w_state_next;
    logic [3:0]       r_op;
    logic [31:0]      r_adrs;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rword;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    cause_e           r_cause;

    width_e           w_in_width;
    width_e           w_width;
    logic             w_in_illegal;
    logic             w_in_misal;
    logic             w_accept;
    logic             w_capture;
    logic             w_timeout;
    logic             w_in_req;
    logic             w_in_resp;
    logic             w_is_store;
    logic [31:0]      w_load_data;

    assign w_in_width   = width_e'(ls_op[OP_WIDTH_MSB:OP_WIDTH_LSB]);
    assign w_in_illegal = (w_in_width == WIDTH_ILL);
    assign w_in_misal   = is_misaligned(w_in_width, ls_adrs[1:0]);
    assign w_width      = width_e'(r_op[OP_WIDTH_MSB:OP_WIDTH_LSB]);
    assign w_is_store   = r_op[OP_RW_BIT];

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ls_valid) begin
                    w_accept     = 1'b1;
                    // Bad requests skip the bus and report the error directly.
                    w_state_next = (w_in_illegal || w_in_misal) ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    w_state_next = w_is_store ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Data that arrives in the last allowed cycle still wins over the timeout.
                if (mem_rvalid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            r_op    <= '0;
            r_adrs  <= '0;
            r_wdata <= '0;
            r_rword <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_cause <= CAUSE_NONE;
        end else begin
            if (w_accept) begin
                r_op    <= ls_op;
                r_adrs  <= ls_adrs;
                r_wdata <= ls_wdata;
                r_rword <= '0;
                r_err   <= w_in_illegal | w_in_misal;
                r_cause <= w_in_illegal ? CAUSE_ILLEGAL :
                           (w_in_misal  ? CAUSE_MISALIGN : CAUSE_NONE);
            end
            if (w_capture) begin
                r_rword <= mem_rdata;
            end
            if (w_timeout) begin
                r_err   <= 1'b1;
                r_cause <= CAUSE_TIMEOUT;
            end
            // The counter runs only in WAIT, so it is zero when WAIT is entered.
            if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    load_align u_load_align (
        .i_word   (r_rword),
        .i_offset (r_adrs[1:0]),
        .i_width  (w_width),
        .i_sign   (r_op[OP_SIGN_BIT]),
        .o_data   (w_load_data)
    );

    assign w_in_req  = (r_state == ST_REQ);
    assign w_in_resp = (r_state == ST_RESP);

    // Bus command fields are zero outside REQ, so the bus idles at a clean state.
    assign ls_ready     = (r_state == ST_IDLE);
    assign mem_req      = w_in_req;
    assign mem_we       = w_in_req & w_is_store;
    assign mem_adrs     = w_in_req ? r_adrs[31:2] : '0;
    assign mem_be       = w_in_req ? byte_enables(w_width, r_adrs[1:0]) : '0;
    assign mem_wdata    = (w_in_req && w_is_store) ? lane_replicate(w_width, r_wdata) : '0;

    assign ls_done      = w_in_resp;
    assign ls_err       = w_in_resp & r_err;
    assign ls_err_cause = w_in_resp ? r_cause : CAUSE_NONE;
    assign ls_rdata     = (w_in_resp && !r_err && !w_is_store) ? w_load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit. The bench acts as the core and as
// the memory. It plays out one access at a time. A reference model built from
// plain arithmetic computes the expected bus command, the result and the
// completion cycle.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk_cpu = 1'b0;
    logic        reset_n;
    logic        ls_valid;
    logic        ls_ready;
    logic [3:0]  ls_op;
    logic [31:0] ls_adrs;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic [1:0]  ls_err_cause;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [29:0] mem_adrs;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int nChecks = 0;
    int nErrors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_cpu      (clk_cpu),
        .reset_n      (reset_n),
        .ls_valid     (ls_valid),
        .ls_ready     (ls_ready),
        .ls_op        (ls_op),
        .ls_adrs      (ls_adrs),
        .ls_wdata     (ls_wdata),
        .ls_done      (ls_done),
        .ls_rdata     (ls_rdata),
        .ls_err       (ls_err),
        .ls_err_cause (ls_err_cause),
        .mem_req      (mem_req),
        .mem_gnt      (mem_gnt),
        .mem_we       (mem_we),
        .mem_adrs     (mem_adrs),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk_cpu = ~clk_cpu;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got time limit reached, expected normal end");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int refCause(input logic [3:0] op, input logic [31:0] adrs);
        int width = int'(op[2:1]);
        int off   = int'(adrs % 4);
        if (width == 3) return 3;
        if (width == 0 && off != 0) return 1;
        if (width == 1 && off % 2 == 1) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] refBe(input logic [3:0] op, input logic [31:0] adrs);
        int width = int'(op[2:1]);
        int off   = int'(adrs % 4);
        if (width == 2) return 32'(1 << off);
        if (width == 1) return 32'(3 << off);
        return 32'd15;
    endfunction

    function automatic logic [31:0] refStoreData(input logic [3:0] op, input logic [31:0] wdata);
        int width = int'(op[2:1]);
        if (width == 2) return (wdata % 256) * 32'h0101_0101;
        if (width == 1) return (wdata % 65536) * 32'h0001_0001;
        return wdata;
    endfunction

    function automatic logic [31:0] refLoadData(input logic [3:0] op, input logic [31:0] adrs,
                                                input logic [31:0] word);
        int width = int'(op[2:1]);
        int off   = int'(adrs % 4);
        logic [31:0] v = word >> (8 * off);
        if (width == 2) begin
            v = v % 256;
            if (op[0] && v >= 128) v = v - 256;
        end else if (width == 1) begin
            v = v % 65536;
            if (op[0] && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"},  32'(ls_ready), 32'd1);
        checkOutput({tag, "_done"},   32'(ls_done), 32'd0);
        checkOutput({tag, "_err"},    32'(ls_err), 32'd0);
        checkOutput({tag, "_cause"},  32'(ls_err_cause), 32'd0);
        checkOutput({tag, "_rdata"},  ls_rdata, 32'd0);
        checkOutput({tag, "_req"},    32'(mem_req), 32'd0);
        checkOutput({tag, "_we"},     32'(mem_we), 32'd0);
        checkOutput({tag, "_be"},     32'(mem_be), 32'd0);
        checkOutput({tag, "_adrs"},   32'(mem_adrs), 32'd0);
        checkOutput({tag, "_wdata"},  mem_wdata, 32'd0);
    endtask

    // One access. gntDelay = wait cycles before the grant. rvDelay = WAIT
    // cycles before rvalid (TIMEOUT or more means rvalid never comes).
    // spurious = random rvalid pulses while the bus phase is still REQ.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] adrs,
                                 input logic [31:0] wdata, input logic [31:0] rword,
                                 input int gntDelay, input int rvDelay, input bit spurious);
        int cause, reqEnd, waitStart, rvCyc, doneCyc, expCause, guard;
        bit isErr, isStore, expReq;
        logic [31:0] expData;

        cause     = refCause(op, adrs);
        isErr     = (cause != 0);
        isStore   = op[3];
        reqEnd    = isErr ? 0 : 1 + gntDelay;
        waitStart = reqEnd + 1;
        rvCyc     = (!isErr && !isStore && rvDelay < TIMEOUT) ? waitStart + rvDelay : -1;
        if (isErr)        doneCyc = 1;
        else if (isStore) doneCyc = reqEnd + 1;
        else              doneCyc = waitStart + ((rvDelay < TIMEOUT) ? rvDelay : TIMEOUT - 1) + 1;
        if (isErr)                                expCause = cause;
        else if (!isStore && rvDelay >= TIMEOUT)  expCause = 2;
        else                                      expCause = 0;
        expData = (expCause == 0 && !isStore) ? refLoadData(op, adrs, rword) : 32'd0;

        guard = 0;
        while (!ls_ready && guard < 50) begin
            @(posedge clk_cpu); #1;
            guard++;
        end
        checkOutput("ready_before", 32'(ls_ready), 32'd1);

        ls_valid = 1'b1; ls_op = op; ls_adrs = adrs; ls_wdata = wdata;
        @(posedge clk_cpu); #1;
        ls_valid = 1'b0; ls_op = 4'($urandom); ls_adrs = $urandom; ls_wdata = $urandom;

        for (int cyc = 1; cyc <= doneCyc; cyc++) begin
            expReq = !isErr && (cyc <= reqEnd);
            checkOutput("mem_req", 32'(mem_req), 32'(expReq));
            if (expReq) begin
                checkOutput("mem_we",   32'(mem_we), 32'(isStore));
                checkOutput("mem_adrs", 32'(mem_adrs), adrs >> 2);
                checkOutput("mem_be",   32'(mem_be), refBe(op, adrs));
                if (isStore) checkOutput("mem_wdata", mem_wdata, refStoreData(op, wdata));
            end
            checkOutput("ls_ready_busy", 32'(ls_ready), 32'd0);
            checkOutput("ls_done", 32'(ls_done), 32'(cyc == doneCyc));
            if (cyc == doneCyc) begin
                checkOutput("ls_err",   32'(ls_err), 32'(expCause != 0));
                checkOutput("ls_cause", 32'(ls_err_cause), 32'(expCause));
                checkOutput("ls_rdata", ls_rdata, expData);
            end
            mem_gnt    = expReq && (cyc == reqEnd);
            mem_rvalid = (cyc == rvCyc) || (spurious && cyc < waitStart && $urandom_range(0, 1) == 1);
            mem_rdata  = (cyc == rvCyc) ? rword : $urandom;
            @(posedge clk_cpu); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        checkOutput("done_pulse_end", 32'(ls_done), 32'd0);
        checkOutput("ready_after", 32'(ls_ready), 32'd1);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] adrs;
        int r, rvDelay;

        reset_n = 1'b0; ls_valid = 1'b0; ls_op = '0; ls_adrs = '0; ls_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #12;
        checkResetValues("por");
        @(posedge clk_cpu); #1;
        reset_n = 1'b1;
        @(posedge clk_cpu); #1;

        $display("[TB] directed accesses");
        applyStimulus(4'b0101, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);  // lb
        applyStimulus(4'b1010, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 3, 0, 1'b0);  // sh
        applyStimulus(4'b0000, 32'h0000_0101, 32'h0, 32'h0, 0, 0, 1'b0);          // lw misaligned
        applyStimulus(4'b0010, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 0, 1'b0);  // lhu
        applyStimulus(4'b0000, 32'h0000_0400, 32'h0, 32'h1234_5678, 1, TIMEOUT, 1'b1);      // timeout
        applyStimulus(4'b0000, 32'h0000_0404, 32'h0, 32'hCAFE_F00D, 0, TIMEOUT - 1, 1'b1);  // last-cycle rvalid
        applyStimulus(4'b0111, 32'h0000_0010, 32'h0, 32'h0, 0, 0, 1'b0);          // illegal width
        applyStimulus(4'b1100, 32'h0000_0013, 32'h0000_005A, 32'h0, 0, 0, 1'b0);  // sb lane 3
        applyStimulus(4'b0011, 32'h0000_0006, 32'h0, 32'h9ABC_0000, 2, 4, 1'b1);  // lh sign

        $display("[TB] reset during WAIT");
        ls_valid = 1'b1; ls_op = 4'b0000; ls_adrs = 32'h0000_0040;
        @(posedge clk_cpu); #1;
        ls_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk_cpu); #1;
        mem_gnt = 1'b0;
        @(posedge clk_cpu); #1;
        checkOutput("rst_pre_req", 32'(mem_req), 32'd0);
        checkOutput("rst_pre_ready", 32'(ls_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        checkResetValues("rst_wait");
        @(posedge clk_cpu); #1;
        reset_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk_cpu); #1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst_no_done", 32'(ls_done), 32'd0);
            checkOutput("rst_ready", 32'(ls_ready), 32'd1);
            checkOutput("rst_no_req", 32'(mem_req), 32'd0);
            @(posedge clk_cpu); #1;
        end

        $display("[TB] random accesses");
        for (int n = 0; n < 200; n++) begin
            op   = 4'($urandom_range(0, 15));
            adrs = $urandom;
            if ($urandom_range(0, 1) == 1) adrs[0] = 1'b0;
            if ($urandom_range(0, 2) == 0) adrs[1] = 1'b0;
            r = $urandom_range(0, 9);
            rvDelay = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 3);
            applyStimulus(op, adrs, $urandom, $urandom, $urandom_range(0, 4), rvDelay,
                          1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, maximum number of cycles spent in WAIT without mem_rvalid before a load aborts.
REQ-002 clk_cpu  in  1  CPU clock; the only clock.
REQ-003 reset_n  in  1  reset, asynchronous and active-low.
REQ-004 ls_valid  in  1  core requests one access; qualified by ls_ready.
REQ-005 ls_ready  out  1  unit idle and accepting a request.
REQ-006 ls_op  in  4  access control {rw[3], width[2:1], sign[0]}; rw 0=read, 1=write; width 00=W, 01=H, 10=B, 11=illegal; sign 1=sign-extend.
REQ-007 ls_adrs  in  32  byte address.
REQ-008 ls_wdata  in  32  store data, right-justified.
REQ-009 ls_done  out  1  one-cycle completion pulse.
REQ-010 ls_rdata  out  32  aligned, extended load result; valid while ls_done=1.
REQ-011 ls_err  out  1  access failed; valid while ls_done=1.
REQ-012 ls_err_cause  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal width.
REQ-013 mem_req  out  1  bus request; held until granted.
REQ-014 mem_gnt  in  1  bus grant; completes the request phase.
REQ-015 mem_we  out  1  1 = write.
REQ-016 mem_adrs  out  30  word address, ls_adrs[31:2].
REQ-017 mem_be  out  4  byte enables.
REQ-018 mem_wdata  out  32  lane-replicated store data.
REQ-019 mem_rvalid  in  1  read data valid.
REQ-020 mem_rdata  in  32  read word.

Function
REQ-021 FSM states: IDLE, REQ, WAIT, RESP; ls_ready=1 only in IDLE.
REQ-022 IDLE: on ls_valid=1, register op, address and data. Misaligned (H with adrs[0]=1; W with adrs[1:0]!=0) or width 11 -> RESP with error and no bus cycle; otherwise -> REQ.
REQ-023 REQ: mem_req=1; mem_we, mem_adrs, mem_be and mem_wdata stable until the grant; mem_gnt=1 -> RESP for a store, WAIT for a load.
REQ-024 WAIT: mem_rvalid=1 -> capture mem_rdata, go to RESP. Counter reaches TIMEOUT_CYCLES without rvalid -> RESP with cause 10.
REQ-025 mem_rvalid outside WAIT is ignored; mem_rvalid in the same cycle as the timeout counts as a success.
REQ-026 RESP: ls_done=1 for exactly one cycle, then IDLE; a new ls_valid is accepted no earlier than the following cycle.
REQ-027 mem_be: B = 0001<<adrs[1:0]; H = 0011<<adrs[1:0]; W = 1111.
REQ-028 mem_wdata: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
REQ-029 Load result: word shifted right by 8*adrs[1:0]; B/H zero- or sign-extended per the sign bit; W unchanged.
REQ-030 ls_rdata = 0 when ls_err=1 and for stores.
REQ-031 Latency from acceptance, with zero-wait grant and response: store done at +2, load done at +3, error done at +1.

Reset
REQ-032 reset_n=0 immediately forces IDLE, clears the timeout counter and the captured registers, and sets mem_req=0, ls_done=0, ls_err=0, ls_err_cause=00, ls_rdata=0, mem_we=0, mem_be=0, mem_adrs=0, mem_wdata=0, ls_ready=1.
REQ-033 Reset during REQ or WAIT abandons the access with no ls_done pulse; a late mem_rvalid after release is ignored.

Structure
REQ-034 The ls_op field positions and encodings, the error-cause codes and the FSM state type reside in the shared CPU definitions package, so they are common with the memory controller.
REQ-035 Read-lane extraction and extension form one combinational sub-module, load_align.

Verification
REQ-036 lb at 0x103, mem_rdata=0x80FF_1234, immediate grant -> mem_be=1000, ls_done at +3, ls_rdata=0xFFFF_FF80.
REQ-037 sh at 0x202, wdata=0x0000_ABCD, mem_gnt delayed 3 cycles -> mem_req held 4 cycles with mem_be=1100 and mem_wdata=0xABCD_ABCD, ls_done 1 cycle after grant.
REQ-038 lw at 0x101 -> no mem_req, ls_done at +1, ls_err=1, cause 01; lhu at 0x002 with rdata 0x8001_0000 -> ls_rdata=0x0000_8001.
REQ-039 Load with mem_rvalid never asserted, TIMEOUT_CYCLES=16 -> ls_done with cause 10 after 16 WAIT cycles; a rvalid in cycle 16 -> success.
REQ-040 reset_n pulsed low during WAIT -> all outputs at reset values that cycle, ls_ready=1 after release, no ls_done for the aborted access.
